req_sync_arbiter: RTL and testbench



---
 rtl/req_sync_arbiter.sv | 126 ++++++++++++
 tb/tb_req_sync_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_sync_arbiter.sv
// Request synchronizer and round-robin arbiter: turns async request edges into
// queued events and issues them one at a time over a start/ack/done handshake.
`timescale 1ns/1ps
module req_sync_arbiter #(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 1023,
  localparam int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req,
  input  logic               res_ack,
  input  logic               res_done,
  output logic               start,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] overrun,
  output logic               timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam int unsigned    WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [NUM_REQ-1:0] r_s1, r_s2, r_s3;
  logic [NUM_REQ-1:0] r_pending, r_overrun;
  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_grant_id, r_last_id;
  logic               r_start, r_busy, r_timeout;
  logic [WD_W-1:0]    r_wd;

  logic [NUM_REQ-1:0] w_edge, w_clr;
  logic [ID_W-1:0]    w_win;
  logic               w_found, w_grant, w_expire, w_timeout;
  logic [1:0]         w_next;

  assign w_edge = r_s2 & ~r_s3;

  // Search order is last_id+1, last_id+2, ... wrapping, so last_id itself comes last.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_win   = r_last_id;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(r_last_id) + k) % NUM_REQ;
      if (!w_found && r_pending[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && w_found;
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_wd == WD_LAST);

  always_comb begin
    w_clr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_clr[i] = w_grant && (w_win == ID_W'(i));
    end
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: if (res_ack) w_next = res_done ? S_IDLE : S_BUSY;
      S_BUSY: begin
        if (res_done) begin
          w_next = S_IDLE;
        end else if (w_expire) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_pending  <= '0;
      r_overrun  <= '0;
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_last_id  <= ID_W'(NUM_REQ - 1);
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_s1      <= async_req;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      // A new edge on the granting cycle re-arms the bit and is not an overrun.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_overrun <= w_edge & r_pending & ~w_clr;
      r_state   <= w_next;
      r_start   <= (w_next == S_ISSUE);
      r_busy    <= (w_next != S_IDLE);
      r_timeout <= w_timeout;
      if (w_grant) begin
        r_grant_id <= w_win;
        r_last_id  <= w_win;
      end
      if (r_state != S_BUSY) r_wd <= '0;
      else                   r_wd <= r_wd + 1'b1;
    end
  end

  assign start       = r_start;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign pending     = r_pending;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_req_sync_arbiter.sv
// Scoreboard bench for req_sync_arbiter: expected grant ids are queued as
// requests are raised and compared when the DUT raises start.
`timescale 1ns/1ps
module tb_req_sync_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TO      = 8;
  localparam int unsigned ID_W    = 2;

  logic               clk = 1'b0;
  logic               n_rst;
  logic [NUM_REQ-1:0] async_req;
  logic               res_ack, res_done;
  logic               start, busy, timeout_err;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] pending, overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic [ID_W-1:0] exp_q[$];

  int   starts = 0, ov1 = 0, ov_any = 0, to_cnt = 0;
  logic start_d = 1'b0;

  req_sync_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .async_req(async_req), .res_ack(res_ack),
    .res_done(res_done), .start(start), .grant_id(grant_id), .busy(busy),
    .pending(pending), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start && !start_d) starts++;
    if (overrun[1]) ov1++;
    if (|overrun) ov_any++;
    if (timeout_err) to_cnt++;
    start_d = start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ID_W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (start === 1'b1) seen = 1'b1;
      else tick();
    end
  endtask

  // done_dly: 0 = done with ack, n>0 = done n cycles after ack
  task automatic serve_job(input int done_dly, output bit seen, output logic [ID_W-1:0] gid);
    gid = 'x;
    wait_start(seen);
    if (!seen) return;
    gid = grant_id;
    res_ack = 1'b1;
    if (done_dly == 0) res_done = 1'b1;
    tick();
    res_ack = 1'b0;
    res_done = 1'b0;
    if (done_dly > 0) begin
      repeat (done_dly - 1) tick();
      res_done = 1'b1;
      tick();
      res_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; async_req = '0; res_ack = 1'b0; res_done = 1'b0;
    repeat (3) tick();
    n_checks++; if (start !== 1'b0) begin n_errors++; $display("FAIL rst_start: got %0h expected 0", start); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    n_checks++; if (grant_id !== '0) begin n_errors++; $display("FAIL rst_grant_id: got %0h expected 0", grant_id); end
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL rst_pending: got %0h expected 0", pending); end
    n_checks++; if (overrun !== '0) begin n_errors++; $display("FAIL rst_overrun: got %0h expected 0", overrun); end
    n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %0h expected 0", timeout_err); end
    n_rst = 1'b1;
    repeat (5) tick();
    n_checks++; if (starts !== 0) begin n_errors++; $display("FAIL rst_idle_starts: got %0d expected 0", starts); end
  endtask

  task automatic test_round_robin();
    bit seen;
    logic [ID_W-1:0] gid, e;
    async_req = 4'b1011;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    for (int j = 0; j < 3; j++) begin
      serve_job(1, seen, gid);
      e = pop_exp();
      n_checks++;
      if (!seen) begin n_errors++; $display("FAIL rr1_grant%0d: no start, expected id %0d", j, e); end
      else if (gid !== e) begin n_errors++; $display("FAIL rr1_grant%0d: got %0d expected %0d", j, gid, e); end
    end
    async_req = '0;
    repeat (6) tick();
    async_req = 4'b0011;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    for (int j = 0; j < 2; j++) begin
      serve_job(1, seen, gid);
      e = pop_exp();
      n_checks++;
      if (!seen) begin n_errors++; $display("FAIL rr2_grant%0d: no start, expected id %0d", j, e); end
      else if (gid !== e) begin n_errors++; $display("FAIL rr2_grant%0d: got %0d expected %0d", j, gid, e); end
    end
    async_req = '0;
    repeat (6) tick();
  endtask

  task automatic test_single();
    logic [ID_W-1:0] e;
    async_req[2] = 1'b1;
    exp_q.push_back(2'd2);
    tick(); tick();
    n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL single_pend_early: got %0h expected 0", pending); end
    tick();
    n_checks++; if (pending !== 4'b0100 || start !== 1'b0) begin n_errors++; $display("FAIL single_pend: got pending=%0h start=%0h expected pending=4 start=0", pending, start); end
    tick();
    e = pop_exp();
    n_checks++;
    if (start !== 1'b1 || busy !== 1'b1 || grant_id !== e || pending !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_grant: got start=%0h busy=%0h id=%0d pending=%0h expected 1 1 %0d 0", start, busy, grant_id, pending, e);
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    n_checks++; if (start !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got start=%0h busy=%0h expected 0 1", start, busy); end
    repeat (4) tick();
    res_done = 1'b1;
    tick();
    res_done = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_done: got busy=%0h expected 0", busy); end
    async_req = '0;
    repeat (5) tick();
  endtask

  task automatic test_overrun();
    bit seen;
    logic [ID_W-1:0] gid, e;
    int ov1_0, ova_0, st_0;
    async_req[2] = 1'b1;
    exp_q.push_back(2'd2);
    wait_start(seen);
    e = pop_exp();
    n_checks++; if (!seen || grant_id !== e) begin n_errors++; $display("FAIL ovr_first_grant: got seen=%0d id=%0d expected id %0d", seen, grant_id, e); end
    ov1_0 = ov1; ova_0 = ova_0 + ov_any;
    exp_q.push_back(2'd1);
    for (int i = 0; i < 16; i++) begin
      async_req[1] = (i < 3) || (i >= 6 && i < 9);
      tick();
    end
    n_checks++; if (ov1 - ov1_0 !== 1) begin n_errors++; $display("FAIL ovr_count: got %0d pulses expected 1", ov1 - ov1_0); end
    n_checks++; if (ov_any - ova_0 !== 1) begin n_errors++; $display("FAIL ovr_other: got %0d total pulses expected 1", ov_any - ova_0); end
    n_checks++; if (pending !== 4'b0010) begin n_errors++; $display("FAIL ovr_pending: got %0h expected 2", pending); end
    res_ack = 1'b1; res_done = 1'b1;
    tick();
    res_ack = 1'b0; res_done = 1'b0;
    serve_job(1, seen, gid);
    e = pop_exp();
    n_checks++; if (!seen || gid !== e) begin n_errors++; $display("FAIL ovr_second_grant: got seen=%0d id=%0d expected id %0d", seen, gid, e); end
    st_0 = starts;
    async_req = '0;
    repeat (15) tick();
    n_checks++; if (starts !== st_0) begin n_errors++; $display("FAIL ovr_extra_grant: got %0d extra starts expected 0", starts - st_0); end
  endtask

  task automatic test_timeout();
    bit seen, dropped;
    logic [ID_W-1:0] e;
    int nb, to_0;
    async_req[3] = 1'b1;
    exp_q.push_back(2'd3);
    wait_start(seen);
    e = pop_exp();
    n_checks++; if (!seen || grant_id !== e) begin n_errors++; $display("FAIL to_grant: got seen=%0d id=%0d expected id %0d", seen, grant_id, e); end
    async_req[0] = 1'b1;
    exp_q.push_back(2'd0);
    to_0 = to_cnt;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    nb = 0; dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1 && !dropped) nb++;
      else dropped = 1'b1;
      tick();
    end
    n_checks++; if (nb !== 8) begin n_errors++; $display("FAIL to_busy_len: got %0d busy cycles expected 8", nb); end
    n_checks++; if (to_cnt - to_0 !== 1) begin n_errors++; $display("FAIL to_pulse: got %0d pulses expected 1", to_cnt - to_0); end
    e = pop_exp();
    n_checks++; if (start !== 1'b1 || grant_id !== e) begin n_errors++; $display("FAIL to_next_grant: got start=%0h id=%0d expected 1 %0d", start, grant_id, e); end
    to_0 = to_cnt;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    repeat (7) tick();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL to_busy8: got busy=%0h expected 1", busy); end
    res_done = 1'b1;
    tick();
    res_done = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL to_done_busy: got %0h expected 0", busy); end
    tick();
    n_checks++; if (to_cnt !== to_0) begin n_errors++; $display("FAIL to_done_prio: got %0d pulses expected 0", to_cnt - to_0); end
    async_req = '0;
    repeat (5) tick();
  endtask

  task automatic test_set_clear();
    bit seen;
    logic [ID_W-1:0] gid, e;
    int ova_0;
    async_req[3] = 1'b1;
    exp_q.push_back(2'd3);
    wait_start(seen);
    e = pop_exp();
    n_checks++; if (!seen || grant_id !== e) begin n_errors++; $display("FAIL sc_first: got seen=%0d id=%0d expected id %0d", seen, grant_id, e); end
    ova_0 = ov_any;
    async_req[0] = 1'b1;
    exp_q.push_back(2'd0);
    repeat (3) tick();
    async_req[0] = 1'b0;
    repeat (4) tick();
    n_checks++; if (pending !== 4'b0001) begin n_errors++; $display("FAIL sc_pending: got %0h expected 1", pending); end
    async_req[0] = 1'b1;
    exp_q.push_back(2'd0);
    tick();
    res_ack = 1'b1; res_done = 1'b1;
    tick();
    res_ack = 1'b0; res_done = 1'b0;
    tick();
    e = pop_exp();
    n_checks++;
    if (start !== 1'b1 || grant_id !== e || pending[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sc_collide: got start=%0h id=%0d pending=%0h expected 1 %0d pending[0]=1", start, grant_id, pending, e);
    end
    res_ack = 1'b1; res_done = 1'b1;
    tick();
    res_ack = 1'b0; res_done = 1'b0;
    serve_job(1, seen, gid);
    e = pop_exp();
    n_checks++; if (!seen || gid !== e) begin n_errors++; $display("FAIL sc_second: got seen=%0d id=%0d expected id %0d", seen, gid, e); end
    tick();
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL sc_drain: got %0h expected 0", pending); end
    n_checks++; if (ov_any !== ova_0) begin n_errors++; $display("FAIL sc_overrun: got %0d pulses expected 0", ov_any - ova_0); end
    async_req = '0;
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [ID_W-1:0] e;
    int st_0, to_0, ova_0;
    async_req[2] = 1'b1;
    exp_q.push_back(2'd2);
    wait_start(seen);
    e = pop_exp();
    n_checks++; if (!seen || grant_id !== e) begin n_errors++; $display("FAIL rm_grant: got seen=%0d id=%0d expected id %0d", seen, grant_id, e); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    async_req = 4'b1110;
    repeat (3) tick();
    n_checks++; if (pending !== 4'b1010 || busy !== 1'b1) begin n_errors++; $display("FAIL rm_setup: got pending=%0h busy=%0h expected a 1", pending, busy); end
    to_0 = to_cnt; ova_0 = ov_any;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({start, busy, grant_id, pending, overrun, timeout_err} !== '0) begin
      n_errors++;
      $display("FAIL rm_async_clear: got start=%0h busy=%0h id=%0d pending=%0h overrun=%0h to=%0h expected all 0",
               start, busy, grant_id, pending, overrun, timeout_err);
    end
    async_req = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    st_0 = starts;
    repeat (30) tick();
    n_checks++; if (starts !== st_0 || busy !== 1'b0 || pending !== '0) begin n_errors++; $display("FAIL rm_after: got starts=%0d busy=%0h pending=%0h expected 0 0 0", starts - st_0, busy, pending); end
    n_checks++; if (to_cnt !== to_0 || ov_any !== ova_0) begin n_errors++; $display("FAIL rm_pulses: got to=%0d ov=%0d expected 0 0", to_cnt - to_0, ov_any - ova_0); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_overrun();
    test_timeout();
    test_set_clear();
    test_reset_mid();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
